// File: rtl/rv_dmem_pkg.sv
// Shared definitions for the rv_dmem data-memory responder: bytectrl codes,
// MMIO word offsets and the misalignment rule.
package rv_dmem_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [2:0] BYTECTRL_B  = 3'b000;
   localparam logic [2:0] BYTECTRL_H  = 3'b001;
   localparam logic [2:0] BYTECTRL_W  = 3'b010;
   localparam logic [2:0] BYTECTRL_BU = 3'b100;
   localparam logic [2:0] BYTECTRL_HU = 3'b101;

   // MMIO offsets expressed as word index a[3:2] inside the 16-byte window
   localparam logic [1:0] MMIO_TOHOST   = 2'd0;
   localparam logic [1:0] MMIO_CYCLE_LO = 2'd1;
   localparam logic [1:0] MMIO_CYCLE_HI = 2'd2;
   localparam logic [1:0] MMIO_SCRATCH  = 2'd3;

   // Unlisted codes behave as word accesses, so they need word alignment too.
   function automatic logic is_misaligned(input logic [1:0] off, input logic [2:0] ctrl);
      logic mis;
      case (ctrl)
         BYTECTRL_B, BYTECTRL_BU: mis = 1'b0;
         BYTECTRL_H, BYTECTRL_HU: mis = off[0];
         default:                 mis = (off != 2'b00);
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/rv_dmem_if.sv
// MEM-stage dmem bus between the pipeline (master) and the data memory (slave).
interface rv_dmem_if;

   logic [rv_dmem_pkg::XLEN-1:0] i_dmem_a;
   logic                         i_dmem_we;
   logic [rv_dmem_pkg::XLEN-1:0] i_dmem_wd;
   logic [2:0]                   i_dmem_bytectrl;
   logic [rv_dmem_pkg::XLEN-1:0] o_dmem_rd;

   modport master (
      output i_dmem_a, i_dmem_we, i_dmem_wd, i_dmem_bytectrl,
      input  o_dmem_rd
   );

   modport slave (
      input  i_dmem_a, i_dmem_we, i_dmem_wd, i_dmem_bytectrl,
      output o_dmem_rd
   );

endinterface

// File: rtl/rv_dmem_lane.sv
// Byte-lane logic: load extract/extend, store byte enables, replicated store data.
// Misalignment detection is active only with RV_DMEM_MISALIGN_CHK_EN defined.
module rv_dmem_lane
   import rv_dmem_pkg::*;
(
   input  logic [1:0]      i_off,
   input  logic [2:0]      i_ctrl,
   input  logic [XLEN-1:0] i_wd,
   input  logic [XLEN-1:0] i_word,
   output logic [XLEN-1:0] o_rd,
   output logic [XLEN-1:0] o_wdata,
   output logic [3:0]      o_be,
   output logic            o_misaligned
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;
   logic        misal_s;

`ifdef RV_DMEM_MISALIGN_CHK_EN
   assign misal_s = is_misaligned(i_off, i_ctrl);
`else
   assign misal_s = 1'b0;
`endif

   // Lane selection ignores the low offset bits that do not matter for the size.
   always_comb begin
      byte_s = 8'h00;
      case (i_off)
         2'd0:    byte_s = i_word[7:0];
         2'd1:    byte_s = i_word[15:8];
         2'd2:    byte_s = i_word[23:16];
         2'd3:    byte_s = i_word[31:24];
         default: byte_s = 8'h00;
      endcase
      half_s = i_off[1] ? i_word[31:16] : i_word[15:0];
   end

   // Extend the selected lane and build store enables; a misaligned access does nothing.
   always_comb begin
      o_rd    = i_word;
      o_wdata = i_wd;
      o_be    = 4'b1111;
      case (i_ctrl)
         BYTECTRL_B: begin
            o_rd    = {{24{byte_s[7]}}, byte_s};
            o_wdata = {4{i_wd[7:0]}};
            o_be    = 4'b0001 << i_off;
         end
         BYTECTRL_BU: begin
            o_rd    = {24'h000000, byte_s};
            o_wdata = {4{i_wd[7:0]}};
            o_be    = 4'b0001 << i_off;
         end
         BYTECTRL_H: begin
            o_rd    = {{16{half_s[15]}}, half_s};
            o_wdata = {2{i_wd[15:0]}};
            o_be    = i_off[1] ? 4'b1100 : 4'b0011;
         end
         BYTECTRL_HU: begin
            o_rd    = {16'h0000, half_s};
            o_wdata = {2{i_wd[15:0]}};
            o_be    = i_off[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            o_rd    = i_word;
            o_wdata = i_wd;
            o_be    = 4'b1111;
         end
      endcase
      if (misal_s) begin
         o_rd = {XLEN{1'b0}};
         o_be = 4'b0000;
      end else begin
         o_be = o_be;
      end
   end

   assign o_misaligned = misal_s;

endmodule

// File: rtl/rv_dmem.sv
// Data memory: word RAM with byte-lane merging plus a 16-byte MMIO window
// (tohost, 64-bit cycle counter, scratch). Optional feature: RV_DMEM_MISALIGN_CHK_EN.
module rv_dmem
   import rv_dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
   input  logic            i_dmem_clk,
   input  logic            i_dmem_rstn,
   rv_dmem_if.slave        bus,
   output logic            o_dmem_tohost_valid,
   output logic [XLEN-1:0] o_dmem_tohost,
   output logic            o_dmem_misaligned,
   output logic [XLEN-1:0] o_dmem_misaligned_a
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);

   logic [XLEN-1:0] mem_q [DEPTH_WORDS];

   logic [AW-1:0]   idx_s;
   logic            mmio_hit_s;
   logic [XLEN-1:0] word_s;
   logic [XLEN-1:0] lane_rd_s;
   logic [XLEN-1:0] wdata_s;
   logic [3:0]      be_s;
   logic            misal_s;
   logic            ram_we_s;
   logic            mmio_we_s;
   logic            wr_tohost_s;
   logic            wr_scratch_s;

   logic [63:0]     cycle_q, cycle_d;
   logic [XLEN-1:0] scratch_q, scratch_d;
   logic [XLEN-1:0] tohost_q, tohost_d;
   logic            tohost_valid_q, tohost_valid_d;

   assign idx_s      = bus.i_dmem_a[AW+1:2];
   assign mmio_hit_s = (bus.i_dmem_a[31:4] == MMIO_BASE[31:4]);
   assign word_s     = mem_q[idx_s];

   rv_dmem_lane u_lane (
      .i_off        (bus.i_dmem_a[1:0]),
      .i_ctrl       (bus.i_dmem_bytectrl),
      .i_wd         (bus.i_dmem_wd),
      .i_word       (word_s),
      .o_rd         (lane_rd_s),
      .o_wdata      (wdata_s),
      .o_be         (be_s),
      .o_misaligned (misal_s)
   );

   assign ram_we_s     = bus.i_dmem_we && !mmio_hit_s;
   assign mmio_we_s    = bus.i_dmem_we && mmio_hit_s && !misal_s;
   assign wr_tohost_s  = mmio_we_s && (bus.i_dmem_a[3:2] == MMIO_TOHOST);
   assign wr_scratch_s = mmio_we_s && (bus.i_dmem_a[3:2] == MMIO_SCRATCH);

   // Load mux: MMIO words ignore bytectrl; RAM goes through the lane extractor.
   always_comb begin
      bus.o_dmem_rd = lane_rd_s;
      if (mmio_hit_s && !misal_s) begin
         case (bus.i_dmem_a[3:2])
            MMIO_CYCLE_LO: bus.o_dmem_rd = cycle_q[31:0];
            MMIO_CYCLE_HI: bus.o_dmem_rd = cycle_q[63:32];
            MMIO_SCRATCH:  bus.o_dmem_rd = scratch_q;
            default:       bus.o_dmem_rd = {XLEN{1'b0}};
         endcase
      end else if (mmio_hit_s) begin
         bus.o_dmem_rd = {XLEN{1'b0}};
      end else begin
         bus.o_dmem_rd = lane_rd_s;
      end
   end

   // RAM is not reset; only the enabled byte lanes of the addressed word change.
   always_ff @(posedge i_dmem_clk) begin
      if (ram_we_s) begin
         for (int i = 0; i < 4; i++) begin
            if (be_s[i]) begin
               mem_q[idx_s][8*i +: 8] <= wdata_s[8*i +: 8];
            end
         end
      end
   end

   // Next-state for counter and MMIO registers; tohost_valid is sticky.
   always_comb begin
      cycle_d        = cycle_q + 64'd1;
      scratch_d      = wr_scratch_s ? bus.i_dmem_wd : scratch_q;
      tohost_d       = wr_tohost_s  ? bus.i_dmem_wd : tohost_q;
      tohost_valid_d = tohost_valid_q || wr_tohost_s;
   end

   // MMIO state flops.
   always_ff @(posedge i_dmem_clk or negedge i_dmem_rstn) begin
      if (!i_dmem_rstn) begin
         cycle_q        <= 64'd0;
         scratch_q      <= {XLEN{1'b0}};
         tohost_q       <= {XLEN{1'b0}};
         tohost_valid_q <= 1'b0;
      end else begin
         cycle_q        <= cycle_d;
         scratch_q      <= scratch_d;
         tohost_q       <= tohost_d;
         tohost_valid_q <= tohost_valid_d;
      end
   end

   assign o_dmem_tohost       = tohost_q;
   assign o_dmem_tohost_valid = tohost_valid_q;

`ifdef RV_DMEM_MISALIGN_CHK_EN
   logic            misal_q, misal_d;
   logic [XLEN-1:0] misal_a_q, misal_a_d;

   // Loads count too: the address is checked every cycle, and only the first hit is kept.
   always_comb begin
      misal_d   = misal_q || misal_s;
      misal_a_d = (misal_s && !misal_q) ? bus.i_dmem_a : misal_a_q;
   end

   // Sticky misalignment record.
   always_ff @(posedge i_dmem_clk or negedge i_dmem_rstn) begin
      if (!i_dmem_rstn) begin
         misal_q   <= 1'b0;
         misal_a_q <= {XLEN{1'b0}};
      end else begin
         misal_q   <= misal_d;
         misal_a_q <= misal_a_d;
      end
   end

   assign o_dmem_misaligned   = misal_q;
   assign o_dmem_misaligned_a = misal_a_q;
`else
   assign o_dmem_misaligned   = 1'b0;
   assign o_dmem_misaligned_a = {XLEN{1'b0}};
`endif

endmodule

// File: tb/tb_rv_dmem.sv
// Directed self-checking bench for rv_dmem; expectations follow the
// RV_DMEM_MISALIGN_CHK_EN build setting.
module tb_rv_dmem;
   import rv_dmem_pkg::*;

   localparam int unsigned DEPTH = 1024;
   localparam logic [31:0] MBASE = 32'hFFFF_0000;

   logic        clk;
   logic        rstn;
   logic        tohost_valid;
   logic [31:0] tohost;
   logic        misaligned;
   logic [31:0] misaligned_a;

   int n_tests = 0;
   int n_fail  = 0;

   rv_dmem_if bus ();

   rv_dmem #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(MBASE)) dut (
      .i_dmem_clk          (clk),
      .i_dmem_rstn         (rstn),
      .bus                 (bus),
      .o_dmem_tohost_valid (tohost_valid),
      .o_dmem_tohost       (tohost),
      .o_dmem_misaligned   (misaligned),
      .o_dmem_misaligned_a (misaligned_a)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_store(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] ctrl);
      @(negedge clk);
      bus.i_dmem_a        = a;
      bus.i_dmem_wd       = wd;
      bus.i_dmem_bytectrl = ctrl;
      bus.i_dmem_we       = 1'b1;
      @(negedge clk);
      bus.i_dmem_we       = 1'b0;
   endtask

   task automatic do_load(input logic [31:0] a, input logic [2:0] ctrl, output logic [31:0] rd);
      @(negedge clk);
      bus.i_dmem_we       = 1'b0;
      bus.i_dmem_a        = a;
      bus.i_dmem_bytectrl = ctrl;
      #1 rd = bus.o_dmem_rd;
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      rstn = 1'b0;
      bus.i_dmem_we = 1'b0; bus.i_dmem_wd = 32'h0; bus.i_dmem_bytectrl = BYTECTRL_W;
      bus.i_dmem_a = MBASE + 32'h4;
      #3 rd = bus.o_dmem_rd;
      n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_cycle_lo: got %h want 00000000", rd); end
      n_tests++; if (tohost_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tohost_valid: got %b want 0", tohost_valid); end
      n_tests++; if (tohost !== 32'h0) begin n_fail++; $display("FAIL reset_tohost: got %h want 00000000", tohost); end
      n_tests++; if (misaligned !== 1'b0) begin n_fail++; $display("FAIL reset_misaligned: got %b want 0", misaligned); end
      n_tests++; if (misaligned_a !== 32'h0) begin n_fail++; $display("FAIL reset_misaligned_a: got %h want 00000000", misaligned_a); end
      @(negedge clk); @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_load_extend();
      logic [31:0] rd;
      do_store(32'h10, 32'h8899AABB, BYTECTRL_W);
      do_load(32'h13, BYTECTRL_B, rd);
      n_tests++; if (rd !== 32'hFFFFFF88) begin n_fail++; $display("FAIL lb_0x13: got %h want FFFFFF88", rd); end
      do_load(32'h13, BYTECTRL_BU, rd);
      n_tests++; if (rd !== 32'h00000088) begin n_fail++; $display("FAIL lbu_0x13: got %h want 00000088", rd); end
      do_load(32'h12, BYTECTRL_H, rd);
      n_tests++; if (rd !== 32'hFFFF8899) begin n_fail++; $display("FAIL lh_0x12: got %h want FFFF8899", rd); end
      do_load(32'h10, BYTECTRL_HU, rd);
      n_tests++; if (rd !== 32'h0000AABB) begin n_fail++; $display("FAIL lhu_0x10: got %h want 0000AABB", rd); end
      do_load(32'h11, BYTECTRL_B, rd);
      n_tests++; if (rd !== 32'hFFFFFFAA) begin n_fail++; $display("FAIL lb_0x11: got %h want FFFFFFAA", rd); end
   endtask

   task automatic test_store_merge();
      logic [31:0] rd;
      do_store(32'h11, 32'h12345677, BYTECTRL_B);
      do_load(32'h10, BYTECTRL_W, rd);
      n_tests++; if (rd !== 32'h889977BB) begin n_fail++; $display("FAIL sb_merge: got %h want 889977BB", rd); end
      do_store(32'h12, 32'h0000CAFE, BYTECTRL_H);
      do_load(32'h10, BYTECTRL_W, rd);
      n_tests++; if (rd !== 32'hCAFE77BB) begin n_fail++; $display("FAIL sh_merge: got %h want CAFE77BB", rd); end
      do_load(32'h10, 3'b011, rd);
      n_tests++; if (rd !== 32'hCAFE77BB) begin n_fail++; $display("FAIL code011_as_w: got %h want CAFE77BB", rd); end
   endtask

   task automatic test_alias();
      logic [31:0] rd;
      do_store(32'h0, 32'h11, BYTECTRL_W);
      do_store(DEPTH * 4, 32'h22, BYTECTRL_W);
      do_load(32'h0, BYTECTRL_W, rd);
      n_tests++; if (rd !== 32'h00000022) begin n_fail++; $display("FAIL alias: got %h want 00000022", rd); end
   endtask

   task automatic test_read_during_write();
      @(negedge clk);
      bus.i_dmem_a = 32'h10; bus.i_dmem_bytectrl = BYTECTRL_W;
      bus.i_dmem_wd = 32'h01020304; bus.i_dmem_we = 1'b1;
      #1;
      n_tests++; if (bus.o_dmem_rd !== 32'hCAFE77BB) begin n_fail++; $display("FAIL rdw_old: got %h want CAFE77BB", bus.o_dmem_rd); end
      @(posedge clk); #1;
      bus.i_dmem_we = 1'b0;
      #1;
      n_tests++; if (bus.o_dmem_rd !== 32'h01020304) begin n_fail++; $display("FAIL rdw_new: got %h want 01020304", bus.o_dmem_rd); end
   endtask

   task automatic test_cycle();
      logic [31:0] rd;
      @(negedge clk); rstn = 1'b0;
      @(negedge clk); rstn = 1'b1;
      // Exactly 100 rising edges see rst_n high here; the window tolerates one either way.
      repeat (100) @(negedge clk);
      bus.i_dmem_we = 1'b0; bus.i_dmem_bytectrl = BYTECTRL_W; bus.i_dmem_a = MBASE + 32'h4;
      #1 rd = bus.o_dmem_rd;
      n_tests++; if (rd < 32'd99 || rd > 32'd101) begin n_fail++; $display("FAIL cycle_100: got %0d want 100+-1", rd); end
      bus.i_dmem_a = MBASE + 32'h8;
      #1 rd = bus.o_dmem_rd;
      n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL cycle_hi_small: got %h want 00000000", rd); end
      @(negedge clk);
      force dut.cycle_q = 64'hFFFF_FFFF_FFFF_FFFF;
      #1 release dut.cycle_q;
      #1 rd = bus.o_dmem_rd;
      n_tests++; if (rd !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL cycle_hi_max: got %h want FFFFFFFF", rd); end
      @(negedge clk);
      bus.i_dmem_a = MBASE + 32'h4;
      #1 rd = bus.o_dmem_rd;
      n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL cycle_wrap_lo: got %h want 00000000", rd); end
      bus.i_dmem_a = MBASE + 32'h8;
      #1 rd = bus.o_dmem_rd;
      n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL cycle_wrap_hi: got %h want 00000000", rd); end
   endtask

   task automatic test_mmio();
      logic [31:0] rd;
      do_store(MBASE, 32'h1, BYTECTRL_W);
      n_tests++; if (tohost_valid !== 1'b1) begin n_fail++; $display("FAIL tohost_valid_set: got %b want 1", tohost_valid); end
      n_tests++; if (tohost !== 32'h1) begin n_fail++; $display("FAIL tohost_1: got %h want 00000001", tohost); end
      do_load(MBASE, BYTECTRL_W, rd);
      n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL tohost_reads_0: got %h want 00000000", rd); end
      do_store(MBASE, 32'h3, BYTECTRL_W);
      n_tests++; if (tohost !== 32'h3) begin n_fail++; $display("FAIL tohost_3: got %h want 00000003", tohost); end
      n_tests++; if (tohost_valid !== 1'b1) begin n_fail++; $display("FAIL tohost_valid_sticky: got %b want 1", tohost_valid); end
      do_store(MBASE + 32'hC, 32'h5A5A1234, BYTECTRL_B);
      do_load(MBASE + 32'hC, BYTECTRL_B, rd);
      n_tests++; if (rd !== 32'h5A5A1234) begin n_fail++; $display("FAIL scratch_rw: got %h want 5A5A1234", rd); end
      do_store(MBASE + 32'h4, 32'h0, BYTECTRL_W);
      do_load(MBASE + 32'h4, BYTECTRL_W, rd);
      n_tests++; if (rd === 32'h0) begin n_fail++; $display("FAIL cycle_lo_ro: got %h want nonzero", rd); end
      // Asynchronous reset between edges must clear MMIO state at once.
      @(posedge clk); #2 rstn = 1'b0;
      bus.i_dmem_a = MBASE + 32'hC;
      #1;
      n_tests++; if (tohost_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst_valid: got %b want 0", tohost_valid); end
      n_tests++; if (tohost !== 32'h0) begin n_fail++; $display("FAIL async_rst_tohost: got %h want 00000000", tohost); end
      n_tests++; if (bus.o_dmem_rd !== 32'h0) begin n_fail++; $display("FAIL async_rst_scratch: got %h want 00000000", bus.o_dmem_rd); end
      @(negedge clk); rstn = 1'b1;
   endtask

   task automatic test_misalign();
      logic [31:0] rd;
      logic [31:0] exp_word, exp_lh, exp_a;
      logic        exp_flag;
`ifdef RV_DMEM_MISALIGN_CHK_EN
      exp_word = 32'h0BADF00D; exp_lh = 32'h0; exp_flag = 1'b1; exp_a = 32'h22;
`else
      exp_word = 32'hDEADBEEF; exp_lh = 32'h00003344; exp_flag = 1'b0; exp_a = 32'h0;
`endif
      do_store(32'h20, 32'h0BADF00D, BYTECTRL_W);
      do_store(32'h30, 32'h11223344, BYTECTRL_W);
      do_store(32'h22, 32'hDEADBEEF, BYTECTRL_W);
      n_tests++; if (misaligned !== exp_flag) begin n_fail++; $display("FAIL misal_flag: got %b want %b", misaligned, exp_flag); end
      n_tests++; if (misaligned_a !== exp_a) begin n_fail++; $display("FAIL misal_a_first: got %h want %h", misaligned_a, exp_a); end
      do_load(32'h20, BYTECTRL_W, rd);
      n_tests++; if (rd !== exp_word) begin n_fail++; $display("FAIL misal_sw_word: got %h want %h", rd, exp_word); end
      do_load(32'h31, BYTECTRL_H, rd);
      n_tests++; if (rd !== exp_lh) begin n_fail++; $display("FAIL misal_lh: got %h want %h", rd, exp_lh); end
      @(negedge clk);
      n_tests++; if (misaligned_a !== exp_a) begin n_fail++; $display("FAIL misal_a_kept: got %h want %h", misaligned_a, exp_a); end
   endtask

   initial begin
      test_reset();
      test_load_extend();
      test_store_merge();
      test_alias();
      test_read_during_write();
      test_cycle();
      test_mmio();
      test_misalign();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
